alu_mc: RTL and testbench

- Multi-cycle execute-stage ALU, directly downstream of the ALU control decoder.
- Consumes the 4-bit ALU op and 3-bit extended compare op together with the two operands. Produces a registered result and a zero flag for writeback and branch resolution.
- Single-cycle ops finish in one clock. MUL runs as an iterative shift-add over WIDTH clocks; busy_o lets the pipeline stall while it runs.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_mul_seq.sv | 72 +++++++
 rtl/alu_mc.sv | 151 +++++++++++++++
 tb/tb_alu_mc.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the multi-cycle execute ALU.
//   ALU_OP_*    : 4-bit ALU op codes (ctrl_i)
//   ALU_EX_OP_* : 3-bit extended compare op codes (ex_ctrl_i); non-zero overrides ctrl_i
//   alu_state_e : top-level sequencing state (IDLE / MUL)
package alu_pkg;

  localparam logic [3:0] ALU_OP_AND  = 4'b0000;
  localparam logic [3:0] ALU_OP_OR   = 4'b0001;
  localparam logic [3:0] ALU_OP_ADD  = 4'b0010;
  localparam logic [3:0] ALU_OP_MUL  = 4'b0011;
  localparam logic [3:0] ALU_OP_SUB  = 4'b0110;
  localparam logic [3:0] ALU_OP_SLT  = 4'b0111;
  localparam logic [3:0] ALU_OP_SLL  = 4'b1000;
  localparam logic [3:0] ALU_OP_SRL  = 4'b1001;
  localparam logic [3:0] ALU_OP_NOR  = 4'b1100;
  localparam logic [3:0] ALU_OP_NAND = 4'b1101;

  localparam logic [2:0] ALU_EX_OP_NONE = 3'b000;
  localparam logic [2:0] ALU_EX_OP_SGT  = 3'b001;
  localparam logic [2:0] ALU_EX_OP_SGE  = 3'b011;
  localparam logic [2:0] ALU_EX_OP_NE   = 3'b100;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative shift-add multiplier, one multiplier bit per clock.
// Produces the low WIDTH bits of the product (same for signed and unsigned).
// Optional macro ALU_MC_MUL_EARLY_TERM_EN: finish as soon as the multiplier
// bits still to be processed are all zero.
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset
//   start_i       : load operands and begin (only honoured when not busy)
//   mcand_i       : multiplicand
//   mplier_i      : multiplier
//   busy_o        : iteration in progress
//   last_o        : the coming edge performs the final step (combinational)
//   product_o     : accumulator after the current step; valid to capture when last_o=1
module alu_mul_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0] mplier_i,
  output logic             busy_o,
  output logic             last_o,
  output logic [WIDTH-1:0] product_o
);

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic [WIDTH-1:0] addend;
  logic             term_hit;

  always_comb begin
    addend    = mplier_q[0] ? mcand_q : '0;
    product_o = acc_q + addend;
`ifdef ALU_MC_MUL_EARLY_TERM_EN
    // Bits above the one consumed this step are all zero: nothing left to add.
    term_hit  = (mplier_q[WIDTH-1:1] == '0) || (cnt_q == CNT_W'(WIDTH - 1));
`else
    term_hit  = (cnt_q == CNT_W'(WIDTH - 1));
`endif
    last_o    = busy_q & term_hit;
    busy_o    = busy_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (start_i && !busy_q) begin
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= mcand_i;
      mplier_q <= mplier_i;
    end else if (busy_q) begin
      acc_q    <= product_o;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (last_o) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle execute-stage ALU.
// Single-cycle logic/arith/shift/compare ops complete at the accept edge;
// MUL runs in alu_mul_seq over WIDTH clocks (or fewer with the optional
// macro ALU_MC_MUL_EARLY_TERM_EN) while busy_o stalls the pipeline.
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset
//   start_i           : request, accepted only while busy_o=0
//   ctrl_i            : 4-bit ALU op
//   ex_ctrl_i         : 3-bit extended compare op, overrides ctrl_i when non-zero
//   src1_i, src2_i    : operands (src1_i[SHAMT_W-1:0] is the shift amount)
//   result_o          : registered result, held between operations
//   zero_o            : result_o == 0
//   busy_o            : MUL in progress
//   done_o            : one-cycle pulse when result_o has been updated
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       ctrl_i,
  input  logic [2:0]       ex_ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             busy_o,
  output logic             done_o
);

  alu_state_e       state_q;
  alu_state_e       state_d;
  logic             accept;
  logic             accept_mul;
  logic             accept_sc;
  logic             mul_busy;
  logic             mul_last;
  logic [WIDTH-1:0] mul_product;
  logic [WIDTH-1:0] result_q;
  logic             done_q;

  function automatic logic [WIDTH-1:0] eval_cmp(input logic [2:0] ex,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic                    bit_r;
    sa = a;
    sb = b;
    case (ex)
      ALU_EX_OP_SGT: bit_r = (sa > sb);
      ALU_EX_OP_SGE: bit_r = (sa >= sb);
      ALU_EX_OP_NE:  bit_r = (a != b);
      default:       bit_r = 1'b0;
    endcase
    return {{(WIDTH-1){1'b0}}, bit_r};
  endfunction

  function automatic logic [WIDTH-1:0] eval_op(input logic [3:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic [WIDTH-1:0]        r;
    sa = a;
    sb = b;
    case (op)
      ALU_OP_AND:  r = a & b;
      ALU_OP_OR:   r = a | b;
      ALU_OP_ADD:  r = a + b;
      ALU_OP_SUB:  r = a - b;
      ALU_OP_SLT:  r = {{(WIDTH-1){1'b0}}, (sa < sb)};
      ALU_OP_NOR:  r = ~(a | b);
      ALU_OP_NAND: r = ~(a & b);
      // Shifts move src2 by the amount in src1.
      ALU_OP_SLL:  r = b << a[SHAMT_W-1:0];
      ALU_OP_SRL:  r = b >> a[SHAMT_W-1:0];
      default:     r = '0;
    endcase
    return r;
  endfunction

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept_mul) state_d = ST_MUL;
      ST_MUL:  if (mul_last)   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / decode logic
  always_comb begin
    accept     = start_i && (state_q == ST_IDLE);
    accept_mul = accept && (ex_ctrl_i == ALU_EX_OP_NONE) && (ctrl_i == ALU_OP_MUL);
    accept_sc  = accept && !accept_mul;
    busy_o     = (state_q == ST_MUL);
  end

  alu_mul_seq #(
    .WIDTH (WIDTH),
    .CNT_W (SHAMT_W)
  ) u_mul (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (accept_mul),
    .mcand_i   (src1_i),
    .mplier_i  (src2_i),
    .busy_o    (mul_busy),
    .last_o    (mul_last),
    .product_o (mul_product)
  );

  // Result / done register: written by a single-cycle op at accept, or by
  // the multiplier on its final step. The two never coincide because MUL
  // completion only happens outside IDLE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept_sc) begin
        result_q <= (ex_ctrl_i != ALU_EX_OP_NONE) ? eval_cmp(ex_ctrl_i, src1_i, src2_i)
                                                  : eval_op(ctrl_i, src1_i, src2_i);
        done_q   <= 1'b1;
      end else if (mul_last && mul_busy) begin
        result_q <= mul_product;
        done_q   <= 1'b1;
      end
    end
  end

  assign result_o = result_q;
  assign done_o   = done_q;
  assign zero_o   = (result_q == '0);

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: self-checking bench for alu_mc. Directed cases plus randomized
// operations compared against a behavioural model. Honours
// ALU_MC_MUL_EARLY_TERM_EN when predicting MUL latency.
module tb_alu_mc;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         start;
  logic [3:0]   ctrl;
  logic [2:0]   ex;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] result;
  logic         zero;
  logic         busy;
  logic         done;

  int n_checks;
  int n_errors;

  alu_mc #(.WIDTH(W), .SHAMT_W(5)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .ctrl_i    (ctrl),
    .ex_ctrl_i (ex),
    .src1_i    (a),
    .src2_i    (b),
    .result_o  (result),
    .zero_o    (zero),
    .busy_o    (busy),
    .done_o    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Behavioural reference: results straight from the op definitions.
  function automatic logic [W-1:0] ref_alu(input logic [3:0] c, input logic [2:0] e,
                                           input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx;
    longint sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (e != 3'b000) begin
      case (e)
        3'b001:  return (sx > sy) ? 1 : 0;
        3'b011:  return (sx >= sy) ? 1 : 0;
        3'b100:  return (x != y) ? 1 : 0;
        default: return 0;
      endcase
    end
    case (c)
      4'b0000: return x & y;
      4'b0001: return x | y;
      4'b0010: return W'(longint'(x) + longint'(y));
      4'b0110: return W'(longint'(x) - longint'(y));
      4'b0111: return (sx < sy) ? 1 : 0;
      4'b1100: return ~(x | y);
      4'b1101: return ~(x & y);
      4'b1000: return W'(longint'(y) << (x % W));
      4'b1001: return W'(longint'(y) >> (x % W));
      4'b0011: return W'(longint'(x) * longint'(y));
      default: return 0;
    endcase
  endfunction

  function automatic int mul_latency(input logic [W-1:0] y);
`ifdef ALU_MC_MUL_EARLY_TERM_EN
    int hb;
    hb = -1;
    for (int i = 0; i < W; i++) if (y[i]) hb = i;
    return (hb < 0) ? 1 : hb + 1;
`else
    return W;
`endif
  endfunction

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 6))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return W'($urandom_range(0, 40));
      default: return W'($urandom);
    endcase
  endfunction

  // Present a request for one edge; returns 1ns after the accept edge.
  task automatic issue(input logic [3:0] c, input logic [2:0] e,
                       input logic [W-1:0] x, input logic [W-1:0] y);
    ctrl  = c;
    ex    = e;
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_single(input string tag, input logic [3:0] c, input logic [2:0] e,
                            input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] exp;
    exp = ref_alu(c, e, x, y);
    issue(c, e, x, y);
    check({tag, "_result"}, result, exp);
    check({tag, "_done"}, W'(done), W'(1));
    check({tag, "_busy"}, W'(busy), W'(0));
    check({tag, "_zero"}, W'(zero), W'(exp == '0));
  endtask

  // Runs a MUL to completion; returns 1ns after the done edge.
  task automatic run_mul(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                         input bit inject);
    int edges;
    int busy_seen;
    int exp_lat;
    logic [W-1:0] exp;
    exp_lat   = mul_latency(y);
    exp       = ref_alu(4'b0011, 3'b000, x, y);
    issue(4'b0011, 3'b000, x, y);
    edges     = 0;
    busy_seen = 0;
    while (!done && edges < W + 4) begin
      if (busy) busy_seen++;
      if (inject && edges == 5) begin
        start = 1'b1;
        ctrl  = 4'b0010;
        ex    = 3'b000;
        a     = 32'h1111_1111;
        b     = 32'h0000_0001;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      edges++;
    end
    check({tag, "_latency"}, W'(edges), W'(exp_lat));
    check({tag, "_busy_cycles"}, W'(busy_seen), W'(exp_lat));
    check({tag, "_result"}, result, exp);
    check({tag, "_done"}, W'(done), W'(1));
    check({tag, "_busy_end"}, W'(busy), W'(0));
  endtask

  initial begin
    int dones;
    logic [3:0]   rc;
    logic [2:0]   re;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] held;
    n_checks = 0;
    n_errors = 0;
    rst   = 1'b1;
    start = 1'b0;
    ctrl  = '0;
    ex    = '0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", result, '0);
    check("rst_done", W'(done), W'(0));
    check("rst_busy", W'(busy), W'(0));
    check("rst_zero", W'(zero), W'(1));
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_single("add_wrap", 4'b0010, 3'b000, 32'd7, 32'hFFFF_FFFF);
    check("add_wrap_val", result, 32'd6);
    @(posedge clk);
    #1;
    check("done_single_pulse", W'(done), W'(0));
    check("result_hold", result, 32'd6);

    run_single("slt_neg", 4'b0111, 3'b000, 32'hFFFF_FFFF, 32'd1);
    check("slt_neg_val", result, 32'd1);
    run_single("sge_eq", 4'b0000, 3'b011, 32'd5, 32'd5);
    check("sge_eq_val", result, 32'd1);
    run_single("ne_eq", 4'b0001, 3'b100, 32'd9, 32'd9);
    check("ne_eq_val", result, 32'd0);
    check("ne_eq_zero", W'(zero), W'(1));

    run_mul("mul_6x-3", 32'd6, 32'hFFFF_FFFD, 1'b1);
    check("mul_6x-3_val", result, 32'hFFFF_FFEE);
    // Back-to-back: request presented in the done cycle.
    run_single("sll_b2b", 4'b1000, 3'b000, 32'd4, 32'd1);
    check("sll_b2b_val", result, 32'd16);

    // Reset after 10 iterations of a MUL.
    issue(4'b0011, 3'b000, 32'd123, 32'hFFFF_FFFF);
    repeat (10) @(posedge clk);
    #1;
    check("mid_mul_busy", W'(busy), W'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_result", result, '0);
    check("mid_rst_busy", W'(busy), W'(0));
    dones = 0;
    for (int i = 0; i < W + 4; i++) begin
      if (done) dones++;
      @(posedge clk);
      #1;
    end
    check("mid_rst_no_done", W'(dones), W'(0));

    run_mul("mul_3x5", 32'd3, 32'd5, 1'b0);
    check("mul_3x5_val", result, 32'd15);
    @(posedge clk);
    #1;
    check("mul_done_pulse", W'(done), W'(0));
    run_mul("mul_x0", 32'hDEAD_BEEF, 32'd0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      re = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
      rc = 4'($urandom_range(0, 15));
      if (i % 7 == 3) begin
        re = 3'b000;
        rc = 4'b0011;
      end
      ra = rand_operand();
      rb = rand_operand();
      if (re == 3'b000 && rc == 4'b0011)
        run_mul($sformatf("rnd%0d_mul", i), ra, rb, 1'($urandom_range(0, 1)));
      else
        run_single($sformatf("rnd%0d_op%0h_ex%0d", i, rc, re), rc, re, ra, rb);
      if ($urandom_range(0, 2) != 0) begin
        held = result;
        a = W'($urandom);
        b = W'($urandom);
        @(posedge clk);
        #1;
        check($sformatf("rnd%0d_idle_done", i), W'(done), W'(0));
        check($sformatf("rnd%0d_idle_hold", i), result, held);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
